// File: rtl/mem_bus_arbiter.sv
// Merges the core's fetch (I) and load/store (D) ports onto one req/ack memory port, with a bus watchdog.
// Optional feature: define ARB_ROUND_ROBIN_EN for alternating grants on simultaneous requests (default: D over I).
module mem_bus_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              IReadEnable,
  input  logic [ADDR_W-1:0] IAddress,
  output logic              IAck,
  output logic [DATA_W-1:0] IReadData,
  input  logic              DReadEnable,
  input  logic              DWriteEnable,
  input  logic [ADDR_W-1:0] DAddress,
  input  logic [DATA_W-1:0] DWriteData,
  input  logic [3:0]        DByteEnable,
  output logic              DAck,
  output logic [DATA_W-1:0] DReadData,
  output logic              MemReq,
  output logic              MemWe,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemWData,
  output logic [3:0]        MemBE,
  input  logic              MemAck,
  input  logic [DATA_W-1:0] MemRData,
  output logic              BusErr
);

  localparam int CNT_W = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
  localparam bit WD_EN = (TIMEOUT != 32'sd0);
  localparam logic [CNT_W-1:0] CNT_LAST = WD_EN ? CNT_W'(TIMEOUT - 1) : {CNT_W{1'b0}};

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_BUSY_I = 2'd1;
  localparam logic [1:0] ST_BUSY_D = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  logic [1:0]       state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             i_req_s;
  logic             d_req_s;
  logic             grant_d_s;
  logic             timeout_s;

`ifdef ARB_ROUND_ROBIN_EN
  logic             last_grant_r;  // 1 = D was granted most recently

  // Remember which side won the most recent grant.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      last_grant_r <= 1'b0;
    end else if ((state_r == ST_IDLE) && (i_req_s || d_req_s)) begin
      last_grant_r <= grant_d_s;
    end
  end
`endif

  // Grant decision and watchdog expiry.
  always_comb begin
    i_req_s   = IReadEnable;
    d_req_s   = DReadEnable | DWriteEnable;
    grant_d_s = d_req_s;
`ifdef ARB_ROUND_ROBIN_EN
    if (i_req_s && d_req_s) begin
      grant_d_s = ~last_grant_r;
    end else begin
      grant_d_s = d_req_s;
    end
`endif
    timeout_s = WD_EN && (cnt_r == CNT_LAST);
  end

  // Transaction FSM with registered memory-side and requester-side outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r   <= ST_IDLE;
      cnt_r     <= {CNT_W{1'b0}};
      MemReq    <= 1'b0;
      MemWe     <= 1'b0;
      MemAddr   <= {ADDR_W{1'b0}};
      MemWData  <= {DATA_W{1'b0}};
      MemBE     <= 4'h0;
      IAck      <= 1'b0;
      DAck      <= 1'b0;
      BusErr    <= 1'b0;
      IReadData <= {DATA_W{1'b0}};
      DReadData <= {DATA_W{1'b0}};
    end else begin
      IAck   <= 1'b0;
      DAck   <= 1'b0;
      BusErr <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (i_req_s || d_req_s) begin
            MemReq <= 1'b1;
            cnt_r  <= {CNT_W{1'b0}};
            if (grant_d_s) begin
              state_r  <= ST_BUSY_D;
              // A simultaneous read+write request is served as a write.
              MemWe    <= DWriteEnable;
              MemAddr  <= DAddress;
              MemWData <= DWriteData;
              MemBE    <= DWriteEnable ? DByteEnable : 4'hF;
            end else begin
              state_r  <= ST_BUSY_I;
              MemWe    <= 1'b0;
              MemAddr  <= IAddress;
              MemWData <= {DATA_W{1'b0}};
              MemBE    <= 4'hF;
            end
          end
        end
        ST_BUSY_I, ST_BUSY_D: begin
          // A real MemAck beats a watchdog expiry in the same cycle.
          if (MemAck || timeout_s) begin
            MemReq  <= 1'b0;
            state_r <= ST_DONE;
            BusErr  <= ~MemAck;
            if (state_r == ST_BUSY_D) begin
              DAck <= 1'b1;
              if (!MemAck) begin
                DReadData <= {DATA_W{1'b0}};
              end else if (!MemWe) begin
                DReadData <= MemRData;
              end
            end else begin
              IAck      <= 1'b1;
              IReadData <= MemAck ? MemRData : {DATA_W{1'b0}};
            end
          end else begin
            cnt_r <= cnt_r + CNT_W'(1'b1);
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
